range_sweep_generator: RTL and testbench
========================================

RANGE_SWEEP_GENERATOR -- requirements
Module: range_sweep_generator

Interface
REQ-001 SHALL have parameter SIZE, default 3200: range bins per sweep.
REQ-002 SHALL have parameter CHANNELS, default 4: independent target outputs.
REQ-003 SHALL have parameter WORD, default 32: pattern load word width; NWORDS = ceil(SIZE*CHANNELS/WORD).
REQ-004 SHALL have port SYS_CLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port SYS_RESETN  in  1  asynchronous reset, active-low.
REQ-006 SHALL have ports EN, TRIG, CLK_PE, MODE_CONT, FLAG_CLR  in  1 each: enable, sweep trigger, bin-advance pulse, continuous mode, sticky-flag clear.
REQ-007 SHALL have ports LOAD_VALID  in  1, LOAD_READY  out  1, LOAD_DATA  in  WORD, LOAD_LAST  in  1: pattern stream.
REQ-008 SHALL have ports GEN_SIGNAL  out  CHANNELS, BUSY  out  1, SWEEP_DONE  out  1, OVERRUN  out  1, UNDERRUN  out  1, LOAD_ERR  out  1.

Function
REQ-009 SHALL hold two pattern buffers of SIZE*CHANNELS bits: active (played) and shadow (loaded); pattern bit index = bin*CHANNELS + channel.
REQ-010 SHALL accept a load word when LOAD_VALID && LOAD_READY; word k fills shadow bits k*WORD..k*WORD+WORD-1; bits beyond SIZE*CHANNELS discarded.
REQ-011 SHALL set PENDING one cycle after accepting word NWORDS-1 with LOAD_LAST=1; LOAD_READY SHALL be 0 while PENDING.
REQ-012 SHALL, if LOAD_LAST mismatches word NWORDS-1 (early or missing), set sticky LOAD_ERR, discard frame, reset word counter to 0.
REQ-013 SHALL implement states IDLE, ARMED, SWEEP: IDLE when EN=0 or no active pattern; ARMED when EN=1, active valid, no sweep; SWEEP while playing.
REQ-014 SHALL, on TRIG with EN=1 in any state: if PENDING, copy shadow to active, clear PENDING, mark active valid; then enter SWEEP at bin 0.
REQ-015 SHALL ignore TRIG when neither active valid nor PENDING, and set sticky UNDERRUN.
REQ-016 SHALL, on TRIG received in SWEEP, restart at bin 0 and set sticky OVERRUN.
REQ-017 SHALL give TRIG priority over CLK_PE in the same cycle; that CLK_PE is dropped.
REQ-018 SHALL advance bin by 1 on each CLK_PE in SWEEP; on CLK_PE at bin SIZE-1: MODE_CONT=1 wraps to bin 0 (swapping if PENDING), else goes to ARMED.
REQ-019 SHALL pulse SWEEP_DONE for one cycle on each end-of-sweep CLK_PE at bin SIZE-1, both modes; not on retrigger.
REQ-020 SHALL register GEN_SIGNAL: one cycle after TRIG or CLK_PE, GEN_SIGNAL[c] = active[bin*CHANNELS+c] in SWEEP, else 0.
REQ-021 SHALL drive BUSY=1 exactly while in SWEEP.
REQ-022 SHALL, on EN falling, return to IDLE next cycle, zero GEN_SIGNAL, keep active/shadow/PENDING; loading SHALL proceed regardless of EN.
REQ-023 SHALL not swap on a TRIG coinciding with the final-word handshake (PENDING not yet set).
REQ-024 SHALL clear OVERRUN, UNDERRUN, LOAD_ERR when FLAG_CLR=1; a same-cycle set event wins.
REQ-025 SHALL size the bin counter to clogb2(SIZE) bits; counter never exceeds SIZE-1.

Reset
REQ-026 SHALL on SYS_RESETN=0 asynchronously: state IDLE, bin 0, active invalid, PENDING 0, word counter 0, all outputs 0 except LOAD_READY=1 after release.
REQ-027 SHALL not require pattern buffer contents to be cleared on reset.
REQ-028 SHALL abort an in-progress sweep or partial load on reset; partial frame discarded.

Structure
REQ-029 SHALL place clogb2 function, state encoding constants in shared package radar_sim_pkg.
REQ-030 SHALL implement shadow buffer, word counter, LOAD_LAST check, PENDING in sub-module pattern_load_buffer.

Verification (SIZE=8, CHANNELS=2, WORD=4, NWORDS=4)
REQ-031 SHALL cover: load 0x1,0x2,0x4,0x8 (LAST on 4th), TRIG, 8 CLK_PE -> GEN_SIGNAL 01,00,10,00,00,01,00,10; SWEEP_DONE one pulse; BUSY low after.
REQ-032 SHALL cover: TRIG before any load -> no sweep, UNDERRUN=1; FLAG_CLR -> UNDERRUN=0.
REQ-033 SHALL cover: TRIG at bin 5 mid-sweep -> bin 0 next, OVERRUN=1, no SWEEP_DONE.
REQ-034 SHALL cover: LOAD_LAST on word 2 -> LOAD_ERR=1, PENDING stays 0, next 4-word frame loads cleanly.
REQ-035 SHALL cover: MODE_CONT=1, second pattern loaded mid-sweep -> wrap at bin 7 plays new pattern from bin 0, SWEEP_DONE pulses each wrap.
REQ-036 SHALL cover: SYS_RESETN low mid-sweep -> GEN_SIGNAL=0, BUSY=0 immediately; TRIG after release -> UNDERRUN=1.

Source files
------------

// File: rtl/radar_sim_pkg.sv
// Shared definitions for the range sweep generator: sweep state encoding
// and small elaboration-time sizing helpers.
package radar_sim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SWEEP = 2'd2
    } sweep_state_t;

    // Bits needed to hold values 0..n-1 (minimum 1).
    function automatic int clogb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/pattern_load_buffer.sv
// Shadow pattern buffer fed by a valid/ready word stream. Tracks the word
// position inside a frame, validates LOAD_LAST against the final word and
// raises pending once a complete frame is held. The consumer clears pending
// with swap_i when it copies the shadow into its active buffer.
module pattern_load_buffer
    import radar_sim_pkg::*;
#(
    parameter int SIZE     = 3200,
    parameter int CHANNELS = 4,
    parameter int WORD     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_valid_i,
    input  logic [WORD-1:0]          load_data_i,
    input  logic                     load_last_i,
    input  logic                     swap_i,
    output logic                     load_ready_o,
    output logic                     pending_o,
    output logic                     load_err_o,
    output logic [SIZE*CHANNELS-1:0] shadow_o
);

    localparam int TOTAL  = SIZE * CHANNELS;
    localparam int NWORDS = ceil_div(TOTAL, WORD);
    localparam int WCW    = clogb2(NWORDS);
    localparam int SIW    = clogb2(TOTAL);
    localparam logic [WCW-1:0] LAST_IDX = WCW'(NWORDS - 1);

    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             pending_q, pending_d;
    logic [TOTAL-1:0] shadow_q;
    logic [SIW-1:0]   wbase;
    logic             accept;
    logic             is_final;
    logic             err;

    // Handshake, frame-position check and next word counter / pending.
    always_comb begin
        accept    = load_valid_i & ~pending_q;
        is_final  = (wcnt_q == LAST_IDX);
        err       = accept & (load_last_i != is_final);
        wbase     = SIW'(wcnt_q) * SIW'(WORD);
        wcnt_d    = wcnt_q;
        pending_d = pending_q & ~swap_i;
        if (accept) begin
            // A frame ends (good or bad) on either the final slot or LAST.
            if (is_final | load_last_i) wcnt_d = '0;
            else                        wcnt_d = wcnt_q + 1'b1;
            if (is_final & load_last_i) pending_d = 1'b1;
        end
    end

    // Frame tracking state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            pending_q <= pending_d;
        end
    end

    // Shadow storage; bits past the pattern length in the last word are dropped.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < WORD; i++) begin
                if (int'(wbase) + i < TOTAL) shadow_q[SIW'(int'(wbase) + i)] <= load_data_i[i];
            end
        end
    end

    assign load_ready_o = ~pending_q;
    assign pending_o    = pending_q;
    assign load_err_o   = err;
    assign shadow_o     = shadow_q;

endmodule

// File: rtl/range_sweep_generator.sv
// Range sweep generator: plays a per-bin, per-channel target pattern out on
// GEN_SIGNAL, advancing one range bin per CLK_PE after a TRIG. A new pattern
// is double-buffered and swapped in on the next trigger or continuous wrap.
module range_sweep_generator
    import radar_sim_pkg::*;
#(
    parameter int SIZE     = 3200,
    parameter int CHANNELS = 4,
    parameter int WORD     = 32
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RESETN,
    input  logic                EN,
    input  logic                TRIG,
    input  logic                CLK_PE,
    input  logic                MODE_CONT,
    input  logic                FLAG_CLR,
    input  logic                LOAD_VALID,
    output logic                LOAD_READY,
    input  logic [WORD-1:0]     LOAD_DATA,
    input  logic                LOAD_LAST,
    output logic [CHANNELS-1:0] GEN_SIGNAL,
    output logic                BUSY,
    output logic                SWEEP_DONE,
    output logic                OVERRUN,
    output logic                UNDERRUN,
    output logic                LOAD_ERR
);

    localparam int TOTAL = SIZE * CHANNELS;
    localparam int BW    = clogb2(SIZE);
    localparam int PIW   = clogb2(TOTAL);
    localparam logic [BW-1:0] LAST_BIN = BW'(SIZE - 1);

    sweep_state_t        state_q;
    logic [BW-1:0]       bin_q, bin_d;
    logic [TOTAL-1:0]    active_q;
    logic                act_valid_q;
    logic [CHANNELS-1:0] gen_q;
    logic                done_q, ovr_q, und_q, lerr_q;

    logic                pending;
    logic                lb_err;
    logic [TOTAL-1:0]    shadow;
    logic                in_sweep, trig_ok, trig_rej, advance, at_end, wrap, swap;
    logic [TOTAL-1:0]    src;
    logic [PIW-1:0]      pbase;
    logic [CHANNELS-1:0] pat_d;

    pattern_load_buffer #(
        .SIZE     (SIZE),
        .CHANNELS (CHANNELS),
        .WORD     (WORD)
    ) u_load (
        .clk_i        (SYS_CLK),
        .rst_ni       (SYS_RESETN),
        .load_valid_i (LOAD_VALID),
        .load_data_i  (LOAD_DATA),
        .load_last_i  (LOAD_LAST),
        .swap_i       (swap),
        .load_ready_o (LOAD_READY),
        .pending_o    (pending),
        .load_err_o   (lb_err),
        .shadow_o     (shadow)
    );

    // Event decode; TRIG masks CLK_PE, and the next bin's pattern is read
    // from the shadow when this cycle swaps it in.
    always_comb begin
        in_sweep = (state_q == ST_SWEEP);
        trig_ok  = EN & TRIG & (pending | act_valid_q);
        trig_rej = EN & TRIG & ~(pending | act_valid_q);
        advance  = EN & ~TRIG & in_sweep & CLK_PE;
        at_end   = (bin_q == LAST_BIN);
        wrap     = advance & at_end & MODE_CONT;
        swap     = pending & (trig_ok | wrap);
        src      = swap ? shadow : active_q;
        bin_d    = (trig_ok | at_end) ? '0 : bin_q + 1'b1;
        pbase    = PIW'(bin_d) * PIW'(CHANNELS);
        pat_d    = src[pbase +: CHANNELS];
    end

    // Sweep FSM with registered bin, GEN_SIGNAL and end-of-sweep pulse.
    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            act_valid_q <= 1'b0;
            gen_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!EN) begin
                state_q <= ST_IDLE;
                bin_q   <= '0;
                gen_q   <= '0;
            end else if (trig_ok) begin
                state_q     <= ST_SWEEP;
                bin_q       <= '0;
                act_valid_q <= 1'b1;
                gen_q       <= pat_d;
            end else if (advance) begin
                bin_q <= bin_d;
                if (at_end) begin
                    done_q <= 1'b1;
                    if (MODE_CONT) begin
                        gen_q <= pat_d;
                    end else begin
                        state_q <= ST_ARMED;
                        gen_q   <= '0;
                    end
                end else begin
                    gen_q <= pat_d;
                end
            end else if (!in_sweep) begin
                state_q <= act_valid_q ? ST_ARMED : ST_IDLE;
                gen_q   <= '0;
            end
        end
    end

    // Active pattern copy on swap; contents are meaningless until first valid.
    always_ff @(posedge SYS_CLK) begin
        if (swap) active_q <= shadow;
    end

    // Sticky status flags; a set event in the clear cycle wins.
    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) begin
            ovr_q  <= 1'b0;
            und_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            ovr_q  <= (trig_ok & in_sweep) | (ovr_q & ~FLAG_CLR);
            und_q  <= trig_rej | (und_q & ~FLAG_CLR);
            lerr_q <= lb_err | (lerr_q & ~FLAG_CLR);
        end
    end

    assign GEN_SIGNAL = gen_q;
    assign BUSY       = in_sweep;
    assign SWEEP_DONE = done_q;
    assign OVERRUN    = ovr_q;
    assign UNDERRUN   = und_q;
    assign LOAD_ERR   = lerr_q;

endmodule

// File: tb/tb_range_sweep_generator.sv
// Bench for range_sweep_generator (SIZE=8, CHANNELS=2, WORD=4): directed
// scenarios followed by random traffic, all checked against a bit-array
// reference model of the sweep and load rules.
module tb_range_sweep_generator;

    localparam int SIZE = 8;
    localparam int CH   = 2;
    localparam int WORD = 4;
    localparam int NW   = 4;
    localparam int TOT  = SIZE * CH;

    logic clk = 1'b0;
    logic rstn, en, trig, pe, cont, clr, lv, ll;
    logic [WORD-1:0] ld;
    logic ready, busy, done, ovr, und, lerr;
    logic [CH-1:0] gen;
    logic [7:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    range_sweep_generator #(.SIZE(SIZE), .CHANNELS(CH), .WORD(WORD)) dut (
        .SYS_CLK    (clk),
        .SYS_RESETN (rstn),
        .EN         (en),
        .TRIG       (trig),
        .CLK_PE     (pe),
        .MODE_CONT  (cont),
        .FLAG_CLR   (clr),
        .LOAD_VALID (lv),
        .LOAD_READY (ready),
        .LOAD_DATA  (ld),
        .LOAD_LAST  (ll),
        .GEN_SIGNAL (gen),
        .BUSY       (busy),
        .SWEEP_DONE (done),
        .OVERRUN    (ovr),
        .UNDERRUN   (und),
        .LOAD_ERR   (lerr)
    );

    always #5 clk = ~clk;

    assign obs = {gen, busy, done, ovr, und, lerr, ready};

    // reference model state
    bit [TOT-1:0] m_sh, m_act;
    int           m_wcnt, m_bin;
    bit           m_pend, m_aval, m_sw, m_done, m_ovr, m_und, m_lerr;
    bit [1:0]     m_gen;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [1:0] pat(input int b);
        return {m_act[b*CH+1], m_act[b*CH]};
    endfunction

    function automatic logic [7:0] exp_out();
        return {m_gen, m_sw, m_done, m_ovr, m_und, m_lerr, ~m_pend};
    endfunction

    function automatic void model_reset();
        m_wcnt = 0; m_bin = 0; m_pend = 0; m_aval = 0; m_sw = 0;
        m_done = 0; m_ovr = 0; m_und = 0; m_lerr = 0; m_gen = 0;
    endfunction

    // One clock edge of behaviour, using the inputs as sampled at that edge.
    function automatic void model_step();
        bit acc;
        acc    = lv && !m_pend;
        m_done = 0;
        if (clr) begin m_ovr = 0; m_und = 0; m_lerr = 0; end
        if (en) begin
            if (trig) begin
                if (m_pend || m_aval) begin
                    if (m_pend) begin m_act = m_sh; m_pend = 0; end
                    m_aval = 1;
                    if (m_sw) m_ovr = 1;
                    m_sw = 1; m_bin = 0; m_gen = pat(0);
                end else begin
                    m_und = 1;
                end
            end else if (m_sw && pe) begin
                if (m_bin == SIZE - 1) begin
                    m_done = 1;
                    m_bin  = 0;
                    if (cont) begin
                        if (m_pend) begin m_act = m_sh; m_pend = 0; end
                        m_gen = pat(0);
                    end else begin
                        m_sw = 0; m_gen = 0;
                    end
                end else begin
                    m_bin++;
                    m_gen = pat(m_bin);
                end
            end
        end else begin
            m_sw = 0; m_bin = 0; m_gen = 0;
        end
        if (acc) begin
            for (int i = 0; i < WORD; i++) m_sh[m_wcnt*WORD+i] = ld[i];
            if (m_wcnt == NW - 1) begin
                if (ll) m_pend = 1; else m_lerr = 1;
                m_wcnt = 0;
            end else if (ll) begin
                m_lerr = 1; m_wcnt = 0;
            end else begin
                m_wcnt++;
            end
        end
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        chk(tag, obs, exp_out());
    endtask

    task automatic pulse_pe(input string tag);
        pe = 1'b1; tick(tag);
        pe = 1'b0; tick(tag);
    endtask

    task automatic do_trig(input string tag);
        trig = 1'b1; tick(tag);
        trig = 1'b0;
    endtask

    task automatic do_clr(input string tag);
        clr = 1'b1; tick(tag);
        clr = 1'b0;
    endtask

    task automatic load_word(input logic [WORD-1:0] d, input logic last);
        lv = 1'b1; ld = d; ll = last;
        tick("load");
        lv = 1'b0; ll = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        model_reset();
        chk(tag, obs, exp_out());
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_gen [8];
        int dones;
        exp_gen = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};

        rstn = 1'b1; en = 0; trig = 0; pe = 0; cont = 0; clr = 0;
        lv = 0; ll = 0; ld = '0;
        m_sh = '0; m_act = '0;
        #1 rstn = 1'b0;
        model_reset();
        #11;
        chk("reset", obs, 8'b0000_0001);
        rstn = 1'b1;

        // trigger with nothing loaded
        en = 1'b1;
        tick("idle");
        do_trig("s2_trig");
        chk("s2_und_set", {7'b0, und}, 8'd1);
        chk("s2_no_busy", {7'b0, busy}, 8'd0);
        do_clr("s2_clr");
        chk("s2_und_clr", {7'b0, und}, 8'd0);

        // basic single sweep
        load_word(4'h1, 1'b0);
        load_word(4'h2, 1'b0);
        load_word(4'h4, 1'b0);
        load_word(4'h8, 1'b1);
        tick("s1_pend");
        chk("s1_ready_low", {7'b0, ready}, 8'd0);
        do_trig("s1_trig");
        chk("s1_gen0", {6'b0, gen}, {6'b0, exp_gen[0]});
        dones = 0;
        for (int b = 1; b <= SIZE; b++) begin
            pe = 1'b1; tick("s1_pe");
            if (b < SIZE) chk("s1_gen", {6'b0, gen}, {6'b0, exp_gen[b]});
            dones += int'(done);
            pe = 1'b0; tick("s1_gap");
            dones += int'(done);
        end
        chk("s1_done_cnt", 8'(dones), 8'd1);
        chk("s1_busy_after", {7'b0, busy}, 8'd0);

        // retrigger mid-sweep
        do_trig("s3_trig");
        for (int b = 0; b < 5; b++) pulse_pe("s3_pe");
        trig = 1'b1; tick("s3_retrig"); trig = 1'b0;
        chk("s3_ovr", {7'b0, ovr}, 8'd1);
        chk("s3_gen_bin0", {6'b0, gen}, 8'd1);
        chk("s3_no_done", {7'b0, done}, 8'd0);
        do_clr("s3_clr");
        for (int b = 0; b < SIZE; b++) pulse_pe("s3_finish");

        // early LOAD_LAST then a clean frame
        load_word(4'h3, 1'b0);
        load_word(4'h4, 1'b0);
        load_word(4'h5, 1'b1);
        chk("s4_lerr", {7'b0, lerr}, 8'd1);
        tick("s4_idle");
        chk("s4_no_pend", {7'b0, ready}, 8'd1);
        load_word(4'h5, 1'b0);
        load_word(4'hA, 1'b0);
        load_word(4'hF, 1'b0);
        load_word(4'h3, 1'b1);
        tick("s4_pend");
        chk("s4_pend_ok", {7'b0, ready}, 8'd0);
        do_clr("s4_clr");

        // continuous mode with a new pattern loaded mid-sweep
        cont = 1'b1;
        do_trig("s5_trig");
        chk("s5_b0", {6'b0, gen}, 8'd1);
        for (int w = 0; w < NW; w++) begin
            lv = 1'b1; pe = 1'b1;
            ld = (w == 0) ? 4'h6 : (w == 1) ? 4'h9 : (w == 2) ? 4'h3 : 4'hC;
            ll = (w == NW - 1);
            tick("s5_load");
            lv = 1'b0; pe = 1'b0; ll = 1'b0;
            tick("s5_gap");
        end
        for (int b = 0; b < 3; b++) pulse_pe("s5_pe");
        pe = 1'b1; tick("s5_wrap");
        chk("s5_wrap_done", {7'b0, done}, 8'd1);
        chk("s5_wrap_new", {6'b0, gen}, 8'd2);
        pe = 1'b0; tick("s5_wrap_gap");
        dones = 0;
        for (int b = 0; b < SIZE; b++) begin
            pe = 1'b1; tick("s5_pe2"); dones += int'(done);
            pe = 1'b0; tick("s5_gap2"); dones += int'(done);
        end
        chk("s5_done_cnt", 8'(dones), 8'd1);
        chk("s5_still_busy", {7'b0, busy}, 8'd1);
        cont = 1'b0;
        for (int b = 0; b < 3; b++) pulse_pe("s6_pe");

        // reset mid-sweep
        #2;
        rstn = 1'b0;
        #1;
        chk("s6_gen_busy", {5'b0, gen, busy}, 8'd0);
        model_reset();
        chk("s6_all", obs, exp_out());
        @(posedge clk);
        #1;
        rstn = 1'b1;
        do_trig("s6_trig");
        chk("s6_und", {7'b0, und}, 8'd1);
        do_clr("s6_clr");

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rand_rst");
            end else begin
                en   = ($urandom_range(0, 39) != 0);
                trig = ($urandom_range(0, 59) == 0);
                pe   = ($urandom_range(0, 1) == 0);
                clr  = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 99) == 0) cont = ~cont;
                lv   = ($urandom_range(0, 1) == 0);
                ld   = 4'($urandom);
                ll   = (m_wcnt == NW - 1) ^ ($urandom_range(0, 19) == 0);
                tick("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
